ex_alu_stage: RTL

Execute-stage ALU and EX/MEM pipeline register for the pipelined RV32 subset core. It consumes the 3-bit ALU control code produced by the ALU control decoder, together with operands and write-back tags from ID/EX. It computes the result and zero flag and registers them into EX/MEM under stall and flush control from the hazard unit. It also keeps a wrap-around count of executed instructions for debug.

---
 rtl/ex_alu_stage_pkg.sv | 16 +
 rtl/ex_alu_stage_if.sv | 45 ++++
 rtl/ex_alu_stage_alu_core.sv | 42 ++++
 rtl/ex_alu_stage.sv | 76 +++++++
 4 files changed

// File: rtl/ex_alu_stage_pkg.sv
// ex_alu_stage_pkg: ALU control code constants shared by the ALU control
// decoder and the execute stage.
//   alu_ctl_t  3-bit ALU control code type
//   ALU_*      control code values
package ex_alu_stage_pkg;

   typedef logic [2:0] alu_ctl_t;

   localparam alu_ctl_t ALU_ADD = 3'b000;
   localparam alu_ctl_t ALU_SUB = 3'b001;
   localparam alu_ctl_t ALU_AND = 3'b010;
   localparam alu_ctl_t ALU_OR  = 3'b011;
   localparam alu_ctl_t ALU_XOR = 3'b100;
   localparam alu_ctl_t ALU_SLT = 3'b101;

endpackage

// File: rtl/ex_alu_stage_if.sv
// ex_alu_stage_if: ID/EX inputs and EX/MEM outputs of the execute stage.
//   i_valid/i_stall/i_flush     slot valid and hazard-unit control
//   i_alu_ctl/i_src_a/i_src_b   ALU code and operands
//   i_imm/i_alu_src             immediate and operand-B select
//   i_rd/i_reg_write/i_branch   write-back and branch tags
//   o_*                         registered EX/MEM contents and exec counter
// modport master: upstream driver; modport slave: the execute stage.
interface ex_alu_stage_if #(
   parameter int WIDTH = 32,
   parameter int RD_W  = 5,
   parameter int CNT_W = 16
);
   logic             i_valid;
   logic             i_stall;
   logic             i_flush;
   logic [2:0]       i_alu_ctl;
   logic [WIDTH-1:0] i_src_a;
   logic [WIDTH-1:0] i_src_b;
   logic [WIDTH-1:0] i_imm;
   logic             i_alu_src;
   logic [RD_W-1:0]  i_rd;
   logic             i_reg_write;
   logic             i_branch;
   logic             o_valid;
   logic [WIDTH-1:0] o_result;
   logic             o_zero;
   logic [RD_W-1:0]  o_rd;
   logic             o_reg_write;
   logic             o_branch_taken;
   logic [CNT_W-1:0] o_exec_cnt;

   modport master (
      output i_valid, i_stall, i_flush, i_alu_ctl, i_src_a, i_src_b, i_imm,
             i_alu_src, i_rd, i_reg_write, i_branch,
      input  o_valid, o_result, o_zero, o_rd, o_reg_write, o_branch_taken,
             o_exec_cnt
   );

   modport slave (
      input  i_valid, i_stall, i_flush, i_alu_ctl, i_src_a, i_src_b, i_imm,
             i_alu_src, i_rd, i_reg_write, i_branch,
      output o_valid, o_result, o_zero, o_rd, o_reg_write, o_branch_taken,
             o_exec_cnt
   );
endinterface

// File: rtl/ex_alu_stage_alu_core.sv
// alu_core: combinational RV32-subset ALU.
//   a, b    operands
//   ctl     ALU control code
//   result  ALU result (0 for unlisted codes)
//   zero    result == 0
// Macro EX_XOR_EN: when defined, code 100 computes a ^ b; otherwise it is
// treated as an unlisted code.
module alu_core
   import ex_alu_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_ctl_t         ctl,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   function automatic logic slt_fn(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y);
      return x < y;
   endfunction

   always_comb begin
      result = '0;
      case (ctl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
`ifdef EX_XOR_EN
         ALU_XOR: result = a ^ b;
`endif
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_fn(a, b)};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU plus EX/MEM pipeline register.
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset, clears every output
//   bus     ex_alu_stage_if.slave: ID/EX inputs, hazard control, EX/MEM outputs
// Register update priority: reset, then flush (kills control, data and
// counter hold), then stall (everything holds), then load.
// Macro EX_XOR_EN (in alu_core) enables the xor code.
module ex_alu_stage
   import ex_alu_stage_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RD_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   ex_alu_stage_if.slave bus
);

   logic [WIDTH-1:0] opb_p0;
   logic [WIDTH-1:0] result_p0;
   logic             zero_p0;

   logic             vld_p1;
   logic [WIDTH-1:0] result_p1;
   logic             zero_p1;
   logic [RD_W-1:0]  rd_p1;
   logic             reg_write_p1;
   logic             branch_taken_p1;
   logic [CNT_W-1:0] cnt_p1;

   assign opb_p0 = bus.i_alu_src ? bus.i_imm : bus.i_src_b;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .a      (bus.i_src_a),
      .b      (opb_p0),
      .ctl    (bus.i_alu_ctl),
      .result (result_p0),
      .zero   (zero_p0)
   );

   // EX -> EX/MEM register boundary
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_p1          <= 1'b0;
         result_p1       <= '0;
         zero_p1         <= 1'b0;
         rd_p1           <= '0;
         reg_write_p1    <= 1'b0;
         branch_taken_p1 <= 1'b0;
         cnt_p1          <= '0;
      end else if (bus.i_flush) begin
         vld_p1          <= 1'b0;
         reg_write_p1    <= 1'b0;
         branch_taken_p1 <= 1'b0;
      end else if (!bus.i_stall) begin
         vld_p1          <= bus.i_valid;
         result_p1       <= result_p0;
         zero_p1         <= zero_p0;
         rd_p1           <= bus.i_rd;
         reg_write_p1    <= bus.i_reg_write & bus.i_valid;
         branch_taken_p1 <= bus.i_branch & zero_p0 & bus.i_valid;
         // Wraps silently at all-ones.
         if (bus.i_valid) cnt_p1 <= cnt_p1 + 1'b1;
      end
   end

   assign bus.o_valid        = vld_p1;
   assign bus.o_result       = result_p1;
   assign bus.o_zero         = zero_p1;
   assign bus.o_rd           = rd_p1;
   assign bus.o_reg_write    = reg_write_p1;
   assign bus.o_branch_taken = branch_taken_p1;
   assign bus.o_exec_cnt     = cnt_p1;

endmodule
